// File: rtl/adc_arb_pkg.sv
// Shared definitions for the ADC readout arbiter: FSM state encoding,
// channel count and one-hot grant constants.
package adc_arb_pkg;

   localparam int N_CHAN = 2;

   // Encoding is visible on OUT_State, so the values are fixed.
   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_SETTLE  = 2'b01,
      S_CONVERT = 2'b10,
      S_DONE    = 2'b11
   } state_t;

   localparam logic [N_CHAN-1:0] GNT_NONE = 2'b00;
   localparam logic [N_CHAN-1:0] GNT_CH0  = 2'b01;
   localparam logic [N_CHAN-1:0] GNT_CH1  = 2'b10;

endpackage

// File: rtl/adc_arb_picker.sv
// Combinational arbitration for the two readout channels.
// Build option: ADC_ARB_FIXED_PRIO_EN selects fixed priority (channel 0
// always wins, last-served pointer ignored); default is round-robin.
module adc_arb_picker
   import adc_arb_pkg::*;
(
   input  logic [N_CHAN-1:0] req_i,
   input  logic              last_served_i,  // 1: channel 1 was served last
   output logic [N_CHAN-1:0] winner_o
);

`ifdef ADC_ARB_FIXED_PRIO_EN
   // Pointer has no meaning with fixed priority.
   logic unused_last_served;
   assign unused_last_served = last_served_i;

   // Channel 0 always wins when both are requesting.
   always_comb begin
      winner_o = GNT_NONE;
      if (req_i[0]) begin
         winner_o = GNT_CH0;
      end else if (req_i[1]) begin
         winner_o = GNT_CH1;
      end
   end
`else
   // Round-robin: a lone requester wins, contention goes to the channel
   // that was not served last.
   always_comb begin
      winner_o = GNT_NONE;
      unique case (req_i)
         2'b01:   winner_o = GNT_CH0;
         2'b10:   winner_o = GNT_CH1;
         2'b11:   winner_o = last_served_i ? GNT_CH0 : GNT_CH1;
         default: winner_o = GNT_NONE;
      endcase
   end
`endif

endmodule

// File: rtl/adc_readout_arbiter.sv
// Shares one ADC between two pixel-row readout channels. A granted row is
// held through a settle window, the ADC is started with a one-cycle pulse,
// the result (or a timeout) is captured and returned with a per-channel ack.
// Build option: ADC_ARB_FIXED_PRIO_EN (see adc_arb_picker).
//
// Handshake: IN_Req[c] is a level held until OUT_Ack[c] pulses for one
// cycle; the requester drops it the cycle after. A request still high in
// IDLE counts as a new request. Withdrawing a request mid-transaction does
// not abort it. OUT_Data is valid while OUT_Ack != 0 and held otherwise.
module adc_readout_arbiter
   import adc_arb_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int SETTLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic              IN_Clock,
   input  logic              IN_Reset,
   input  logic [N_CHAN-1:0] IN_Req,
   input  logic              IN_ADC_Ready,
   input  logic [DATA_W-1:0] IN_ADC_Data,
   output logic [N_CHAN-1:0] OUT_Grant,
   output logic              OUT_ADC_Start,
   output logic [N_CHAN-1:0] OUT_Ack,
   output logic [DATA_W-1:0] OUT_Data,
   output logic              OUT_Timeout,
   output logic [1:0]        OUT_State
);

   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   // Settle counter runs 0..SETTLE_CYCLES-1, one value per settle cycle.
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
   // Timeout counter is 0 in the start cycle, then k in post-start cycle k.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

   state_t              state_q, state_d;
   logic [N_CHAN-1:0]   grant_q, grant_d;
   logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
   logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                tmo_flag_q, tmo_flag_d;
   logic                last_q, last_d;
   logic [N_CHAN-1:0]   pick;

   adc_arb_picker u_picker (
      .req_i         (IN_Req),
      .last_served_i (last_q),
      .winner_o      (pick)
   );

   // State and datapath registers; reset drops the grant immediately.
   always_ff @(posedge IN_Clock or negedge IN_Reset) begin
      if (!IN_Reset) begin
         state_q    <= S_IDLE;
         grant_q    <= GNT_NONE;
         set_cnt_q  <= '0;
         tmo_cnt_q  <= '0;
         data_q     <= '0;
         tmo_flag_q <= 1'b0;
         last_q     <= 1'b1;   // channel 0 wins the first contention
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         set_cnt_q  <= set_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         data_q     <= data_d;
         tmo_flag_q <= tmo_flag_d;
         last_q     <= last_d;
      end
   end

   // Next-state logic and the strobe outputs decoded from the current state.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      set_cnt_d     = set_cnt_q;
      tmo_cnt_d     = tmo_cnt_q;
      data_d        = data_q;
      tmo_flag_d    = tmo_flag_q;
      last_d        = last_q;
      OUT_ADC_Start = 1'b0;
      OUT_Ack       = GNT_NONE;
      OUT_Timeout   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (IN_Req != GNT_NONE) begin
               grant_d   = pick;
               set_cnt_d = '0;
               state_d   = S_SETTLE;
            end
         end

         S_SETTLE: begin
            if (set_cnt_q == SET_LAST) begin
               tmo_cnt_d  = '0;
               tmo_flag_d = 1'b0;
               state_d    = S_CONVERT;
            end else begin
               set_cnt_d = set_cnt_q + 1'b1;
            end
         end

         S_CONVERT: begin
            if (tmo_cnt_q == '0) begin
               // Start cycle: Ready from a previous conversion is ignored.
               OUT_ADC_Start = 1'b1;
               tmo_cnt_d     = TMO_ONE;
            end else if (IN_ADC_Ready) begin
               data_d  = IN_ADC_Data;
               state_d = S_DONE;
            end else if (tmo_cnt_q == TMO_LAST) begin
               data_d     = '0;
               tmo_flag_d = 1'b1;
               state_d    = S_DONE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end

         S_DONE: begin
            OUT_Ack     = grant_q;
            OUT_Timeout = tmo_flag_q;
            last_d      = grant_q[1];
            grant_d     = GNT_NONE;
            set_cnt_d   = '0;
            tmo_cnt_d   = '0;
            state_d     = S_IDLE;
         end

         default: begin
            grant_d = GNT_NONE;
            state_d = S_IDLE;
         end
      endcase
   end

   assign OUT_Grant = grant_q;
   assign OUT_Data  = data_q;
   assign OUT_State = state_q;

endmodule
